// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with a one-word hold buffer for gapless frames.
// Optional build macro PARITY_EN appends an even-parity bit after the data bits of each frame.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no frame on the line, data_out at IDLE_LEVEL
// ST_SHIFT  | data bits of a frame on data_out, bit_cnt tracks position
// ST_PARITY | parity bit on data_out (PARITY_EN builds only)
module piso_serializer #(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             data_out,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

`ifdef PARITY_EN
    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] ST_PARITY = 2'd2;
`else
    localparam int ST_W = 1;
`endif
    localparam logic [ST_W-1:0] ST_IDLE  = ST_W'(0);
    localparam logic [ST_W-1:0] ST_SHIFT = ST_W'(1);

    logic [ST_W-1:0]  state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_en_q, ready_en_d;
`ifdef PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             xfer;
    logic             load;
    logic             end_frame;
    logic [WIDTH-1:0] load_word;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Shifter keeps the not-yet-sent bits aligned so the next bit is always at the send end.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // Ready is held off for the first clock after reset release.
    assign word_ready = ready_en_q && !hold_full_q;
    assign xfer       = word_valid && word_ready;

    assign data_out = data_q;
    assign busy     = busy_q;
    assign done     = done_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        data_d      = data_q;
        busy_d      = busy_q;
        done_d      = done_q;
        ready_en_d  = 1'b1;
`ifdef PARITY_EN
        parity_d    = parity_q;
`endif
        load      = 1'b0;
        end_frame = 1'b0;
        load_word = word_in;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    load = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == CNT_LAST) begin
`ifdef PARITY_EN
                    state_d = ST_PARITY;
                    data_d  = parity_q;
                    done_d  = 1'b1;
                    if (xfer) begin
                        hold_d      = word_in;
                        hold_full_d = 1'b1;
                    end
`else
                    end_frame = 1'b1;
`endif
                end else begin
                    data_d    = first_bit(shift_q);
                    shift_d   = advance(shift_q);
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
`ifdef PARITY_EN
                    done_d    = 1'b0;
`else
                    done_d    = (bit_cnt_q == CNT_PENULT);
`endif
                    if (xfer) begin
                        hold_d      = word_in;
                        hold_full_d = 1'b1;
                    end
                end
            end
`ifdef PARITY_EN
            ST_PARITY: begin
                end_frame = 1'b1;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Hold takes priority at the frame boundary; a same-edge transfer refills it.
        if (end_frame) begin
            if (hold_full_q) begin
                load        = 1'b1;
                load_word   = hold_q;
                hold_full_d = xfer;
                if (xfer) begin
                    hold_d = word_in;
                end
            end else if (xfer) begin
                load = 1'b1;
            end else begin
                state_d = ST_IDLE;
                data_d  = IDLE_LEVEL;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        end

        if (load) begin
            state_d   = ST_SHIFT;
            data_d    = first_bit(load_word);
            shift_d   = advance(load_word);
            bit_cnt_d = '0;
            busy_d    = 1'b1;
            done_d    = 1'b0;
`ifdef PARITY_EN
            parity_d  = ^load_word;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            data_q      <= IDLE_LEVEL;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_en_q  <= 1'b0;
`ifdef PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ready_en_q  <= ready_en_d;
`ifdef PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a queue-of-bits model checked every cycle on an MSB-first and
// an LSB-first instance, plus hand-computed stream literals (honours PARITY_EN if defined).
module tb_piso_serializer;

    localparam int W = 4;
`ifdef PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif
    localparam int LOGN = 4096;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] word_in = '0;
    logic         word_valid = 1'b0;

    logic rdy_m, do_m, busy_m, done_m;
    logic rdy_l, do_l, busy_l, done_l;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .word_ready(rdy_m), .data_out(do_m), .busy(busy_m), .done(done_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .word_ready(rdy_l), .data_out(do_l), .busy(busy_l), .done(done_l)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic lg_dm [0:LOGN-1];
    logic lg_dl [0:LOGN-1];
    logic lg_bm [0:LOGN-1];
    logic lg_dn [0:LOGN-1];
    logic lg_rd [0:LOGN-1];

    // Model: remaining bits of the frame on the line, plus words accepted but not yet started.
    bit           qm[$];
    bit           ql[$];
    logic [W-1:0] pend[$];
    bit           ready_en = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                qm.delete();
                ql.delete();
                pend.delete();
                ready_en = 1'b0;
            end else begin
                logic         xfer;
                logic [W-1:0] w;
                xfer = word_valid && ready_en && (pend.size() == 0);
                if (qm.size() > 0) begin
                    void'(qm.pop_front());
                    void'(ql.pop_front());
                end
                if (xfer) pend.push_back(word_in);
                if (qm.size() == 0 && pend.size() > 0) begin
                    w = pend.pop_front();
                    for (int i = 0; i < W; i++) begin
                        qm.push_back(w[W-1-i]);
                        ql.push_back(w[i]);
                    end
`ifdef PARITY_EN
                    qm.push_back(^w);
                    ql.push_back(^w);
`endif
                end
                ready_en = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("ready_m", rdy_m, (ready_en && pend.size() == 0) ? 8'd1 : 8'd0);
            check("ready_l", rdy_l, (ready_en && pend.size() == 0) ? 8'd1 : 8'd0);
            check("busy_m",  busy_m, (qm.size() > 0) ? 8'd1 : 8'd0);
            check("busy_l",  busy_l, (ql.size() > 0) ? 8'd1 : 8'd0);
            check("data_m",  do_m, (qm.size() > 0) ? {7'd0, qm[0]} : 8'd0);
            check("data_l",  do_l, (ql.size() > 0) ? {7'd0, ql[0]} : 8'd0);
            check("done_m",  done_m, (qm.size() == 1) ? 8'd1 : 8'd0);
            check("done_l",  done_l, (ql.size() == 1) ? 8'd1 : 8'd0);
            if (cyc < LOGN) begin
                lg_dm[cyc] = do_m;
                lg_dl[cyc] = do_l;
                lg_bm[cyc] = busy_m;
                lg_dn[cyc] = done_m;
                lg_rd[cyc] = rdy_m;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge just after the transfer edge.
    task automatic drive(input logic [W-1:0] w);
        logic r;
        int   guard;
        guard = 0;
        word_valid = 1'b1;
        word_in    = w;
        do begin
            r = rdy_m;
            @(negedge clk);
            guard++;
        end while (!r && guard < 50);
        if (!r) check("drive_timeout", 8'd0, 8'd1);
        word_valid = 1'b0;
    endtask

    task automatic chk_log(input string name, input int s, input int n,
                           input logic [15:0] exp, input int sel);
        logic a;
        for (int i = 0; i < n; i++) begin
            case (sel)
                0:       a = lg_dm[s+i];
                1:       a = lg_dl[s+i];
                2:       a = lg_bm[s+i];
                3:       a = lg_dn[s+i];
                default: a = lg_rd[s+i];
            endcase
            check(name, {7'd0, a}, {7'd0, exp[n-1-i]});
        end
    endtask

    task automatic settle();
        repeat (2 * FRAME + 3) @(negedge clk);
    endtask

    initial begin
        int s;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", rdy_m, 8'd1);

        // single word; MSB-first and LSB-first instances side by side
        drive(4'b1011);
        s = cyc;
        settle();
`ifdef PARITY_EN
        chk_log("single_data_m", s, 5, 16'b10111, 0);
        chk_log("single_data_l", s, 5, 16'b11011, 1);
        chk_log("single_done",   s, 5, 16'b00001, 3);
        chk_log("single_busy",   s, 6, 16'b111110, 2);
`else
        chk_log("single_data_m", s, 4, 16'b1011, 0);
        chk_log("single_data_l", s, 4, 16'b1101, 1);
        chk_log("single_done",   s, 4, 16'b0001, 3);
        chk_log("single_busy",   s, 5, 16'b11110, 2);
`endif
        chk_log("single_idle", s + FRAME, 1, 16'b0, 0);

        // back-to-back with valid held, second word waits in hold
        drive(4'b1100);
        s = cyc;
        drive(4'b0101);
        settle();
`ifdef PARITY_EN
        chk_log("b2b_data",  s, 10, 16'b1100001010, 0);
        chk_log("b2b_done",  s, 10, 16'b0000100001, 3);
        chk_log("b2b_ready", s, 6,  16'b100001, 4);
`else
        chk_log("b2b_data",  s, 8, 16'b11000101, 0);
        chk_log("b2b_done",  s, 8, 16'b00010001, 3);
        chk_log("b2b_ready", s, 5, 16'b10001, 4);
`endif
        chk_log("b2b_busy", s, 2 * FRAME + 1, 16'hFFFF << 1, 2);

        // bypass: next word offered only on the last bit cycle
        drive(4'b1111);
        s = cyc;
        repeat (FRAME - 1) @(negedge clk);
        drive(4'b0001);
        settle();
`ifdef PARITY_EN
        chk_log("bypass_data", s, 10, 16'b1111000011, 0);
`else
        chk_log("bypass_data", s, 8, 16'b11110001, 0);
`endif
        chk_log("bypass_busy", s, 2 * FRAME, 16'hFFFF, 2);

        // async reset mid-frame, then a fresh word from its first bit
        drive(4'b1010);
        #2 rst = 1'b1;
        #1;
        check("rst_data_m", do_m, 8'd0);
        check("rst_busy_m", busy_m, 8'd0);
        check("rst_done_m", done_m, 8'd0);
        check("rst_data_l", do_l, 8'd0);
        check("rst_busy_l", busy_l, 8'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("ready_held_after_release", rdy_m, 8'd0);
        @(negedge clk);
        check("ready_one_clk_after_release", rdy_m, 8'd1);
        drive(4'b0110);
        s = cyc;
        settle();
`ifdef PARITY_EN
        chk_log("post_rst_data", s, 5, 16'b01100, 0);
`else
        chk_log("post_rst_data", s, 4, 16'b0110, 0);
`endif

`ifdef PARITY_EN
        drive(4'b0111);
        s = cyc;
        settle();
        chk_log("parity_0111_data", s, 5, 16'b01111, 0);
        chk_log("parity_0111_done", s, 5, 16'b00001, 3);
        drive(4'b0110);
        s = cyc;
        settle();
        chk_log("parity_0110_data", s, 5, 16'b01100, 0);
`endif

        // three words with valid held continuously; model checks the stream
        drive(4'b1001);
        drive(4'b0011);
        drive(4'b1110);
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
